// File: rtl/wb_fifo_irq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wb_fifo_irq_pkg
// Brief    : Register indices, bit positions and field offsets shared by the
//            Wishbone FIFO peripheral and its storage core.
// Revision : 1.0 - initial release
// ============================================================================
package wb_fifo_irq_pkg;

  // Register indices, decoded from wb_adr_i[4:2]
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_RXDATA  = 3'd1;
  localparam logic [2:0] REG_TXDATA  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_THRESH  = 3'd4;
  localparam logic [2:0] REG_IRQSTAT = 3'd5;

  // IRQSTAT / irq_en bit positions
  localparam int IRQ_AE  = 0;
  localparam int IRQ_AF  = 1;
  localparam int IRQ_OVF = 2;
  localparam int IRQ_UNF = 3;

  // CTRL bit positions
  localparam int CTRL_FLUSH      = 0;
  localparam int CTRL_IRQ_EN_LSB = 4;

  // STATUS field offsets
  localparam int ST_EMPTY     = 0;
  localparam int ST_AEMPTY    = 1;
  localparam int ST_AFULL     = 2;
  localparam int ST_FULL      = 3;
  localparam int ST_LEVEL_LSB = 16;

  // THRESH field offsets
  localparam int THR_AE_LSB = 0;
  localparam int THR_AF_LSB = 16;

endpackage
`default_nettype wire

// File: rtl/wb_fifo_irq_core.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core
// Brief    : Single-clock FIFO storage: memory, read/write pointers and a
//            fill-level counter. Push/pop are gated by full/empty; flush
//            clears pointers and level but leaves memory contents alone.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full_level = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   c_lvl_one    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one    = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_level == c_full_level);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push & ~full & ~flush;
  assign w_do_pop  = pop & ~empty & ~flush;

  // Storage write; memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and level bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_fifo_irq.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo_irq
// Brief    : Wishbone-slave FIFO peripheral with fill level, almost-full /
//            almost-empty thresholds, sticky event flags, soft flush and a
//            maskable level-sensitive interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo_irq #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_RESET   = 2**DEPTH_LOG2 - 1,
  parameter int AE_RESET   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  import wb_fifo_irq_pkg::*;

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] c_ae_reset = LW'(AE_RESET);
  localparam logic [LW-1:0] c_af_reset = LW'(AF_RESET);
  localparam logic [LW-1:0] c_lvl_one  = LW'(1);

  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_irq;
  logic [LW-1:0]         r_ae;
  logic [LW-1:0]         r_af;
  logic [3:0]            r_irq_en;
  logic [3:0]            r_irqstat;

  logic [2:0]            w_reg;
  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  logic [LW-1:0]         w_level;
  logic [LW-1:0]         w_level_next;
  logic                  w_full;
  logic                  w_empty;
  logic [3:0]            w_set;
  logic [3:0]            w_clr;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // A new request is only accepted while no ack is outstanding, so every
  // side effect below happens exactly once per access.
  assign w_reg   = wb_adr_i[4:2];
  assign w_req   = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr    = w_req & wb_we_i;
  assign w_rd    = w_req & ~wb_we_i;
  assign w_push  = w_wr && (w_reg == REG_TXDATA);
  assign w_pop   = w_rd && (w_reg == REG_RXDATA);
  assign w_flush = w_wr && (w_reg == REG_CTRL) && wb_dat_i[CTRL_FLUSH];

  assign wb_ack_o = wb_stb_i & wb_cyc_i & r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (wb_dat_i[DATA_WIDTH-1:0]),
    .rdata (w_fifo_rdata),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Level the core will hold after this cycle, used for threshold edge detection
  always_comb begin
    w_level_next = w_level;
    if (w_flush) begin
      w_level_next = '0;
    end else if (w_push && !w_full) begin
      w_level_next = w_level + c_lvl_one;
    end else if (w_pop && !w_empty) begin
      w_level_next = w_level - c_lvl_one;
    end
  end

  // Event sources and W1C mask; threshold edges need an actual level change
  always_comb begin
    w_set          = '0;
    w_set[IRQ_AE]  = (w_level_next <= r_ae) && (w_level > r_ae);
    w_set[IRQ_AF]  = (w_level_next >= r_af) && (w_level < r_af);
    w_set[IRQ_OVF] = w_push & w_full;
    w_set[IRQ_UNF] = w_pop & w_empty;
    w_clr          = (w_wr && (w_reg == REG_IRQSTAT)) ? wb_dat_i[3:0] : 4'd0;
  end

  // Read-data mux; unused and reserved bits read 0
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_STATUS: begin
        w_rdata[ST_EMPTY]               = w_empty;
        w_rdata[ST_AEMPTY]              = (w_level <= r_ae);
        w_rdata[ST_AFULL]               = (w_level >= r_af);
        w_rdata[ST_FULL]                = w_full;
        w_rdata[ST_LEVEL_LSB +: LW]     = w_level;
      end
      REG_RXDATA: begin
        w_rdata[DATA_WIDTH-1:0] = w_empty ? '0 : w_fifo_rdata;
      end
      REG_CTRL: begin
        w_rdata[CTRL_IRQ_EN_LSB +: 4]   = r_irq_en;
      end
      REG_THRESH: begin
        w_rdata[THR_AE_LSB +: LW]       = r_ae;
        w_rdata[THR_AF_LSB +: LW]       = r_af;
      end
      REG_IRQSTAT: begin
        w_rdata[3:0]                    = r_irqstat;
      end
      default: w_rdata = '0;
    endcase
  end

  // Bus handshake: one-cycle ack, read data captured at the request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd) begin
        r_dat <= w_rdata;
      end
    end
  end

  // Software-visible control registers: thresholds, irq enables, sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ae      <= c_ae_reset;
      r_af      <= c_af_reset;
      r_irq_en  <= '0;
      r_irqstat <= '0;
    end else begin
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_irq_en <= wb_dat_i[CTRL_IRQ_EN_LSB +: 4];
      end
      if (w_wr && (w_reg == REG_THRESH)) begin
        r_ae <= wb_dat_i[THR_AE_LSB +: LW];
        r_af <= wb_dat_i[THR_AF_LSB +: LW];
      end
      // set takes priority over a simultaneous write-1-to-clear
      r_irqstat <= (r_irqstat & ~w_clr) | w_set;
    end
  end

  // Interrupt line follows the masked flags one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_irqstat & r_irq_en);
    end
  end

endmodule
`default_nettype wire
